// File: rtl/rv32im_pkg.sv
// rv32im_pkg: shared opcodes, ALU/branch/write-back codes and the ID/EX register layout
// for the RV32IM decode/execute slice.
package rv32im_pkg;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_SUB    = 5'b01000;
    localparam logic [4:0] ALU_SLL    = 5'b00001;
    localparam logic [4:0] ALU_SLT    = 5'b00010;
    localparam logic [4:0] ALU_SLTU   = 5'b00011;
    localparam logic [4:0] ALU_XOR    = 5'b00100;
    localparam logic [4:0] ALU_SRL    = 5'b00101;
    localparam logic [4:0] ALU_SRA    = 5'b01101;
    localparam logic [4:0] ALU_OR     = 5'b00110;
    localparam logic [4:0] ALU_AND    = 5'b00111;
    localparam logic [4:0] ALU_PASS_B = 5'b01111;
    localparam logic [4:0] ALU_MUL    = 5'b10000;
    localparam logic [4:0] ALU_MULH   = 5'b10001;
    localparam logic [4:0] ALU_MULHSU = 5'b10010;
    localparam logic [4:0] ALU_MULHU  = 5'b10011;
    localparam logic [4:0] ALU_DIV    = 5'b10100;
    localparam logic [4:0] ALU_DIVU   = 5'b10101;
    localparam logic [4:0] ALU_REM    = 5'b10110;
    localparam logic [4:0] ALU_REMU   = 5'b10111;

    localparam logic [3:0] BR_NONE = 4'b0000;
    localparam logic [3:0] BR_JUMP = 4'b1010;
    localparam logic [3:0] BR_EQ   = 4'b1000;
    localparam logic [3:0] BR_NE   = 4'b1001;
    localparam logic [3:0] BR_LT   = 4'b1100;
    localparam logic [3:0] BR_GE   = 4'b1101;
    localparam logic [3:0] BR_LTU  = 4'b1110;
    localparam logic [3:0] BR_GEU  = 4'b1111;

    localparam logic [1:0] WB_MEM  = 2'b00;
    localparam logic [1:0] WB_ALU  = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b11;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;

    // All-zero is the bubble: ADD 0+0, no branch, no write-back, no memory access.
    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] link;
        logic [4:0]  alu_sel;
        logic [3:0]  branch;
        logic        jalr;
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  wb_sel;
        logic [3:0]  mem_read;
        logic [2:0]  mem_write;
    } idex_t;
endpackage

// File: rtl/rv32im_decode_execute_if.sv
// rv32im_decode_execute_if: IF/ID inputs and EX outputs of the decode/execute slice.
interface rv32im_decode_execute_if;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC_IN;
    logic [31:0] RS1_DATA;
    logic [31:0] RS2_DATA;
    logic        STALL;
    logic        FLUSH;
    logic [31:0] ALU_OUT;
    logic        BRANCH_TAKEN;
    logic [31:0] RS2_DATA_OUT;
    logic [31:0] LINK_ADDR;
    logic [4:0]  RD_ADDR;
    logic        REG_WRITE_EN;
    logic [1:0]  REG_WRITE_SELECT;
    logic [3:0]  MEM_READ;
    logic [2:0]  MEM_WRITE;

    modport master (
        output INSTRUCTION, PC_IN, RS1_DATA, RS2_DATA, STALL, FLUSH,
        input  ALU_OUT, BRANCH_TAKEN, RS2_DATA_OUT, LINK_ADDR, RD_ADDR,
               REG_WRITE_EN, REG_WRITE_SELECT, MEM_READ, MEM_WRITE
    );
    modport slave (
        input  INSTRUCTION, PC_IN, RS1_DATA, RS2_DATA, STALL, FLUSH,
        output ALU_OUT, BRANCH_TAKEN, RS2_DATA_OUT, LINK_ADDR, RD_ADDR,
               REG_WRITE_EN, REG_WRITE_SELECT, MEM_READ, MEM_WRITE
    );
endinterface

// File: rtl/rv32im_alu.sv
// rv32im_alu: combinational RV32IM ALU; unknown select codes yield 0.
module rv32im_alu
    import rv32im_pkg::*;
(
    input  logic [4:0]  alu_sel_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o
);
    logic [63:0] a_x, b_x, prod;
    logic [31:0] sra, b_u, b_s;
    logic signed [31:0] q_s, r_s;
    logic div0, ovf;

    // One 64-bit multiplier serves all four variants by choosing the operand extension.
    assign a_x  = {{32{a_i[31] & (alu_sel_i == ALU_MULH || alu_sel_i == ALU_MULHSU)}}, a_i};
    assign b_x  = {{32{b_i[31] & (alu_sel_i == ALU_MULH)}}, b_i};
    assign prod = a_x * b_x;
    assign sra  = $signed(a_i) >>> b_i[4:0];
    assign div0 = b_i == 32'd0;
    assign ovf  = a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF;
    // Divisors are forced to 1 in the corner cases so the dividers never see /0 or overflow.
    assign b_u  = div0 ? 32'd1 : b_i;
    assign b_s  = (div0 || ovf) ? 32'd1 : b_i;
    assign q_s  = $signed(a_i) / $signed(b_s);
    assign r_s  = $signed(a_i) % $signed(b_s);

    always_comb begin
        result_o = '0;
        case (alu_sel_i)
            ALU_ADD:    result_o = a_i + b_i;
            ALU_SUB:    result_o = a_i - b_i;
            ALU_SLL:    result_o = a_i << b_i[4:0];
            ALU_SLT:    result_o = {31'd0, $signed(a_i) < $signed(b_i)};
            ALU_SLTU:   result_o = {31'd0, a_i < b_i};
            ALU_XOR:    result_o = a_i ^ b_i;
            ALU_SRL:    result_o = a_i >> b_i[4:0];
            ALU_SRA:    result_o = sra;
            ALU_OR:     result_o = a_i | b_i;
            ALU_AND:    result_o = a_i & b_i;
            ALU_PASS_B: result_o = b_i;
            ALU_MUL:    result_o = prod[31:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: result_o = prod[63:32];
            ALU_DIV:    result_o = div0 ? '1 : ovf ? a_i : q_s;
            ALU_DIVU:   result_o = div0 ? '1 : a_i / b_u;
            ALU_REM:    result_o = div0 ? a_i : ovf ? '0 : r_s;
            ALU_REMU:   result_o = div0 ? a_i : a_i % b_u;
            default:    result_o = '0;
        endcase
    end
endmodule

// File: rtl/rv32im_decode_execute.sv
// rv32im_decode_execute: decodes the IF/ID instruction into the ID/EX register, then runs
// the ALU and branch comparator on the registered operands.
module rv32im_decode_execute
    import rv32im_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic CLK,
    input  logic RESET,
    rv32im_decode_execute_if.slave bus
);
    logic [31:0] instr, imm;
    logic [6:0]  opc;
    logic [2:0]  f3;
    imm_t        itype;
    logic        op1_pc, op2_imm, legal, wb;
    idex_t       idex_d, idex_q;
    logic [XLEN-1:0] alu_res;
    logic        eq, lt, ltu;

    assign instr = bus.INSTRUCTION;
    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign itype = (opc == OPC_LUI || opc == OPC_AUIPC) ? IMM_U :
                   opc == OPC_JAL    ? IMM_J :
                   opc == OPC_BRANCH ? IMM_B :
                   opc == OPC_STORE  ? IMM_S : IMM_I;

    always_comb begin
        imm = {{20{instr[31]}}, instr[31:20]};
        case (itype)
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = {{20{instr[31]}}, instr[31:20]};
        endcase
    end

    always_comb begin
        idex_d = '0;
        op1_pc = 1'b0;
        op2_imm = 1'b1;
        legal = 1'b1;
        wb = 1'b1;
        idex_d.wb_sel = WB_ALU;
        case (opc)
            OPC_LUI:    idex_d.alu_sel = ALU_PASS_B;
            OPC_AUIPC:  op1_pc = 1'b1;
            OPC_JAL:    begin op1_pc = 1'b1; idex_d.branch = BR_JUMP; idex_d.wb_sel = WB_LINK; end
            OPC_JALR:   begin idex_d.jalr = 1'b1; idex_d.branch = BR_JUMP; idex_d.wb_sel = WB_LINK; end
            OPC_BRANCH: begin op1_pc = 1'b1; idex_d.branch = {1'b1, f3}; wb = 1'b0; end
            OPC_LOAD:   begin idex_d.mem_read = {1'b1, f3}; idex_d.wb_sel = WB_MEM; end
            OPC_STORE:  begin idex_d.mem_write = {1'b1, f3[1:0]}; wb = 1'b0; end
            OPC_OP_IMM: idex_d.alu_sel = {1'b0, instr[30] & (f3 == 3'b101), f3};
            OPC_OP:     begin op2_imm = 1'b0; idex_d.alu_sel = {instr[25], instr[30], f3}; end
            default:    legal = 1'b0;
        endcase
        idex_d.op1  = op1_pc ? bus.PC_IN : bus.RS1_DATA;
        idex_d.op2  = op2_imm ? imm : bus.RS2_DATA;
        idex_d.rs1  = bus.RS1_DATA;
        idex_d.rs2  = bus.RS2_DATA;
        idex_d.link = bus.PC_IN + 32'd4;
        idex_d.rd   = instr[11:7];
        idex_d.we   = wb & (instr[11:7] != 5'd0);
        if (!legal) idex_d = '0;
    end

    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) idex_q <= '0;
        else if (!bus.STALL) idex_q <= bus.FLUSH ? '0 : idex_d;

    rv32im_alu u_alu (
        .alu_sel_i(idex_q.alu_sel),
        .a_i      (idex_q.op1),
        .b_i      (idex_q.op2),
        .result_o (alu_res)
    );

    // Branch bit0 inverts the base test: NE, GE and GEU are the complements of EQ, LT and LTU.
    assign eq  = idex_q.rs1 == idex_q.rs2;
    assign lt  = $signed(idex_q.rs1) < $signed(idex_q.rs2);
    assign ltu = idex_q.rs1 < idex_q.rs2;
    assign bus.BRANCH_TAKEN = idex_q.branch == BR_JUMP ? 1'b1 :
                              !idex_q.branch[3] ? 1'b0 :
                              idex_q.branch[2:1] == 2'b00 ? eq ^ idex_q.branch[0] :
                              idex_q.branch[2:1] == 2'b10 ? lt ^ idex_q.branch[0] :
                              idex_q.branch[2:1] == 2'b11 ? ltu ^ idex_q.branch[0] : 1'b0;

    assign bus.ALU_OUT          = idex_q.jalr ? {alu_res[31:1], 1'b0} : alu_res;
    assign bus.RS2_DATA_OUT     = idex_q.rs2;
    assign bus.LINK_ADDR        = idex_q.link;
    assign bus.RD_ADDR          = idex_q.rd;
    assign bus.REG_WRITE_EN     = idex_q.we;
    assign bus.REG_WRITE_SELECT = idex_q.wb_sel;
    assign bus.MEM_READ         = idex_q.mem_read;
    assign bus.MEM_WRITE        = idex_q.mem_write;
endmodule

// File: tb/tb_rv32im_decode_execute.sv
// tb_rv32im_decode_execute: randomized and directed stimulus, scoreboarded against an
// instruction-level reference model.
module tb_rv32im_decode_execute;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rv32im_decode_execute_if bus();
    rv32im_decode_execute dut (.CLK(clk), .RESET(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic        taken;
        logic [31:0] rs2;
        logic [31:0] link;
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  wsel;
        logic [3:0]  mr;
        logic [2:0]  mw;
        logic        chk_wb;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur = '0;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", name, got, want);
        end
    endtask

    task automatic compare_all(input string tag, input exp_t e);
        chk({tag, ".alu_out"}, bus.ALU_OUT, e.alu);
        chk({tag, ".branch_taken"}, {31'd0, bus.BRANCH_TAKEN}, {31'd0, e.taken});
        chk({tag, ".rs2_out"}, bus.RS2_DATA_OUT, e.rs2);
        chk({tag, ".link"}, bus.LINK_ADDR, e.link);
        chk({tag, ".we"}, {31'd0, bus.REG_WRITE_EN}, {31'd0, e.we});
        chk({tag, ".mem_read"}, {28'd0, bus.MEM_READ}, {28'd0, e.mr});
        chk({tag, ".mem_write"}, {29'd0, bus.MEM_WRITE}, {29'd0, e.mw});
        if (e.chk_wb) begin
            chk({tag, ".rd"}, {27'd0, bus.RD_ADDR}, {27'd0, e.rd});
            chk({tag, ".wsel"}, {30'd0, bus.REG_WRITE_SELECT}, {30'd0, e.wsel});
        end
    endtask

    function automatic logic [31:0] base_op(input logic [2:0] f3, input logic alt,
                                            input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return (sa < sb) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'(sa >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [31:0] m_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint pa, pb;
        logic [63:0] p;
        int sa, sb;
        sa = a;
        sb = b;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        case (f3)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = pa * pb; return p[63:32]; end
            3'd2: begin p = pa * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [2:0] f3;
        logic [31:0] ii, si, bi, ui, ji;
        int sa, sb;
        logic wb;
        e = '0;
        f3 = ins[14:12];
        wb = 1'b1;
        sa = a;
        sb = b;
        ii = {{20{ins[31]}}, ins[31:20]};
        si = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        bi = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        ui = {ins[31:12], 12'd0};
        ji = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        e.wsel = 2'b01;
        case (ins[6:0])
            7'b0110111: e.alu = ui;
            7'b0010111: e.alu = pc + ui;
            7'b1101111: begin e.alu = pc + ji; e.taken = 1'b1; e.wsel = 2'b11; end
            7'b1100111: begin e.alu = (a + ii) & ~32'd1; e.taken = 1'b1; e.wsel = 2'b11; end
            7'b1100011: begin
                e.alu = pc + bi;
                wb = 1'b0;
                e.taken = (f3 == 3'd0) ? (a == b) : (f3 == 3'd1) ? (a != b) :
                          (f3 == 3'd4) ? (sa < sb) : (f3 == 3'd5) ? (sa >= sb) :
                          (f3 == 3'd6) ? (a < b) : (a >= b);
            end
            7'b0000011: begin e.alu = a + ii; e.mr = {1'b1, f3}; e.wsel = 2'b00; end
            7'b0100011: begin e.alu = a + si; e.mw = {1'b1, f3[1:0]}; wb = 1'b0; end
            7'b0010011: e.alu = base_op(f3, ins[30] && f3 == 3'd5, a, ii);
            7'b0110011: e.alu = ins[25] ? m_op(f3, a, b) : base_op(f3, ins[30], a, b);
            default: return '0;
        endcase
        e.rs2 = b;
        e.link = pc + 32'd4;
        e.rd = ins[11:7];
        e.we = wb && ins[11:7] != 5'd0;
        e.chk_wb = wb;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0] ops [9];
        logic [2:0] bfs [6];
        int k, k2;
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
        bfs = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        w = $urandom;
        k = $urandom_range(0, 10);
        if (k >= 9) begin
            w[1:0] = 2'($urandom_range(0, 2));
            return w;
        end
        w[6:0] = ops[k];
        if (ops[k] == 7'b1100011) w[14:12] = bfs[$urandom_range(0, 5)];
        if (ops[k] == 7'b0110011) begin
            k2 = $urandom_range(0, 2);
            w[31:25] = (k2 == 1) ? 7'h01 :
                       (k2 == 2 && (w[14:12] == 3'd0 || w[14:12] == 3'd5)) ? 7'h20 : 7'h00;
        end
        return w;
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    task automatic apply(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic st, input logic fl);
        @(negedge clk);
        rst_n = 1'b1;
        bus.INSTRUCTION = ins;
        bus.PC_IN = pc;
        bus.RS1_DATA = a;
        bus.RS2_DATA = b;
        bus.STALL = st;
        bus.FLUSH = fl;
        if (!st) begin
            if (fl) cur = '0;
            else cur = model(ins, pc, a, b);
        end
        exp_q.push_back(cur);
        @(posedge clk);
        #2;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) compare_all("pipe", exp_q.pop_front());
    end

    localparam logic [31:0] ADDI_X5 = 32'hFFD00293;
    localparam logic [31:0] DIV_I   = {7'h01, 5'd2, 5'd1, 3'b100, 5'd3, 7'b0110011};
    localparam logic [31:0] REM_I   = {7'h01, 5'd2, 5'd1, 3'b110, 5'd3, 7'b0110011};
    localparam logic [31:0] MULHU_I = {7'h01, 5'd2, 5'd1, 3'b011, 5'd3, 7'b0110011};
    localparam logic [31:0] BEQ_I   = {7'd0, 5'd2, 5'd1, 3'b000, 5'b01000, 7'b1100011};
    localparam logic [31:0] JALR_I  = {12'd3, 5'd2, 3'b000, 5'd1, 7'b1100111};
    localparam logic [31:0] SW_I    = {7'd0, 5'd3, 5'd2, 3'b010, 5'd4, 7'b0100011};

    exp_t zero_full;
    int r;

    initial begin
        zero_full = '0;
        zero_full.chk_wb = 1'b1;
        bus.INSTRUCTION = '0;
        bus.PC_IN = '0;
        bus.RS1_DATA = '0;
        bus.RS2_DATA = '0;
        bus.STALL = 1'b0;
        bus.FLUSH = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset", zero_full);

        apply(ADDI_X5, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("addi.alu", bus.ALU_OUT, 32'hFFFF_FFFD);
        chk("addi.rd", {27'd0, bus.RD_ADDR}, 32'd5);
        chk("addi.we", {31'd0, bus.REG_WRITE_EN}, 32'd1);
        chk("addi.wsel", {30'd0, bus.REG_WRITE_SELECT}, 32'd1);
        apply(SW_I, 32'h40, 32'h1000, 32'h1234, 1'b1, 1'b0);
        chk("stall.alu", bus.ALU_OUT, 32'hFFFF_FFFD);
        chk("stall.rd", {27'd0, bus.RD_ADDR}, 32'd5);
        apply(SW_I, 32'h40, 32'h1000, 32'hCAFE_BABE, 1'b0, 1'b0);
        chk("sw.mem_write", {29'd0, bus.MEM_WRITE}, 32'b110);
        chk("sw.rs2_out", bus.RS2_DATA_OUT, 32'hCAFE_BABE);
        chk("sw.alu", bus.ALU_OUT, 32'h1004);
        apply(SW_I, 32'h44, 32'h1000, 32'h5, 1'b0, 1'b1);
        chk("flush.we", {31'd0, bus.REG_WRITE_EN}, 32'd0);
        chk("flush.mem_write", {29'd0, bus.MEM_WRITE}, 32'd0);
        chk("flush.mem_read", {28'd0, bus.MEM_READ}, 32'd0);
        chk("flush.taken", {31'd0, bus.BRANCH_TAKEN}, 32'd0);
        apply(DIV_I, 32'h50, 32'd7, 32'd0, 1'b0, 1'b0);
        chk("div0", bus.ALU_OUT, 32'hFFFF_FFFF);
        apply(REM_I, 32'h54, 32'd7, 32'd0, 1'b0, 1'b0);
        chk("rem0", bus.ALU_OUT, 32'd7);
        apply(DIV_I, 32'h58, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("div_ovf", bus.ALU_OUT, 32'h8000_0000);
        apply(MULHU_I, 32'h5C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("mulhu", bus.ALU_OUT, 32'hFFFF_FFFE);
        apply(BEQ_I, 32'h100, 32'd4, 32'd4, 1'b0, 1'b0);
        chk("beq_t.taken", {31'd0, bus.BRANCH_TAKEN}, 32'd1);
        chk("beq_t.alu", bus.ALU_OUT, 32'h108);
        apply(BEQ_I, 32'h100, 32'd4, 32'd5, 1'b0, 1'b0);
        chk("beq_nt.taken", {31'd0, bus.BRANCH_TAKEN}, 32'd0);
        apply(JALR_I, 32'h400, 32'h200, 32'h0, 1'b0, 1'b0);
        chk("jalr.alu", bus.ALU_OUT, 32'h202);
        chk("jalr.link", bus.LINK_ADDR, 32'h404);
        chk("jalr.wsel", {30'd0, bus.REG_WRITE_SELECT}, 32'b11);

        // Asynchronous reset asserted between clock edges.
        #1 rst_n = 1'b0;
        #1 compare_all("async_reset", zero_full);
        cur = '0;

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            apply(rand_instr(), $urandom & ~32'd3, rand_val(), rand_val(), r == 0, r == 1);
        end

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
